// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, result buffered with its PC for decode.
// Optional FETCH_PERF_EN adds saturating fetch/bubble performance counters.
module fetch_stage #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t state, state_d;
  logic   drop, drop_d;
  logic   valid_d;
  logic   capture;
  logic   unused_target_lsbs;

  assign unused_target_lsbs = ^redirect_target[1:0];
  assign imem_addr = pc;

  always_comb begin
    state_d = state;
    drop_d  = drop;
    valid_d = if_valid;
    capture = 1'b0;
    unique case (state)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_d = WAIT;
          drop_d  = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          // A redirect arriving together with the data kills it just like a pending drop.
          if (drop || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            capture = 1'b1;
            valid_d = 1'b1;
            state_d = DRAIN;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      DRAIN: begin
        if (redirect_valid || id_ready) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) valid_d = 1'b0;
  end

  always_comb begin
    if (redirect_valid)
      pc_next = {redirect_target[ADDR_W-1:2], 2'b00};
    else if (capture)
      pc_next = pc + ADDR_W'(PC_STEP);
    else
      pc_next = pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      drop     <= 1'b0;
      imem_req <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      state    <= state_d;
      drop     <= drop_d;
      imem_req <= (state_d == REQ);
      if_valid <= valid_d;
      if (capture) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (capture && perf_fetch_cnt != '1)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_ready && !if_valid && state != IDLE && perf_bubble_cnt != '1)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage, directly downstream of the program counter register.
- Takes the registered PC, issues one instruction-memory read at a time through a req/gnt/rvalid handshake, and buffers the returned word with its PC tag for decode.
- Drives pc_next back into the program counter's PC input, so the PC advances only when an instruction is captured or a redirect occurs.

Parameters:
- ADDR_W, 32, PC and memory address width.
- DATA_W, 32, instruction width.
- PC_STEP, 4, increment applied to the PC on each captured instruction.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset; low clears all state immediately.
- pc  in  ADDR_W  current PC from the program counter register.
- pc_next  out  ADDR_W  combinational next PC, wired to the program counter's PC input.
- imem_req  out  1  read request, registered.
- imem_addr  out  ADDR_W  read address; equals pc.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  DATA_W  read data.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_target  in  ADDR_W  new PC.
- if_valid  out  1  buffered instruction available.
- if_instr  out  DATA_W  buffered instruction.
- if_pc  out  ADDR_W  PC of the buffered instruction.
- id_ready  in  1  decode accepts the instruction; transfer happens when if_valid and id_ready are both 1.

Behaviour:
- Reset (rst low, async) values:
  - state=IDLE, imem_req=0, if_valid=0, if_instr=0, if_pc=0, drop=0.
  - Any imem_rvalid arriving after reset release while not in WAIT is ignored.
- FSM states: IDLE, REQ, WAIT, DRAIN. imem_req=1 exactly when state==REQ.
- IDLE: go to REQ next cycle unconditionally. Gives a one-cycle gap after reset release.
- REQ: if imem_gnt=1, go to WAIT; otherwise stay in REQ. Memory samples imem_addr only on the gnt cycle.
- WAIT:
  - imem_rvalid=1 with drop=0: capture imem_rdata into if_instr, pc into if_pc, set if_valid=1, go to DRAIN.
  - imem_rvalid=1 with drop=1: discard the data, clear drop, go to REQ.
- DRAIN: when if_valid and id_ready are both 1, clear if_valid and go to REQ in the same cycle.
- Outstanding requests: at most one at any time. A new request is never issued while if_valid=1.
- pc_next priority:
  1. redirect_valid: {redirect_target[ADDR_W-1:2], 2'b00}.
  2. Capture cycle (WAIT, rvalid=1, drop=0, no redirect): pc + PC_STEP.
  3. Otherwise: pc, so the PC holds.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFFFFFC + 4 = 0x00000000.
- Redirect handling. Redirect always clears if_valid; any transfer in that same cycle is void.
  - IDLE or DRAIN: go to REQ.
  - REQ with imem_gnt=1: go to WAIT with drop=1.
  - REQ without gnt: stay in REQ; the address follows the new pc next cycle.
  - WAIT with imem_rvalid=0: set drop=1, stay in WAIT.
  - WAIT with imem_rvalid=1: discard the data, clear drop, go to REQ.
- Latency: request-to-capture is 1 (REQ) + gnt wait + rvalid wait cycles. Best-case throughput is one instruction per 3 cycles with id_ready held high.
- if_instr and if_pc hold their values while in DRAIN, and are unchanged after a flush.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0]. Both reset to 0 and saturate at 0xFFFFFFFF.
  - perf_fetch_cnt increments on each non-dropped capture.
  - perf_bubble_cnt increments each cycle with id_ready=1, if_valid=0 and state!=IDLE.
- Undefined: these ports and counters do not exist, and there is no other change in behaviour.

Test Plan:
- Reset release with pc=0 and memory returning gnt in REQ and rvalid one cycle later with rdata=0x20010005, id_ready=1 -> imem_req asserted in cycle 2. if_valid=1 with if_instr=0x20010005 and if_pc=0. pc_next=4 in the capture cycle, then 8 on the next capture.
- id_ready=0 for 5 cycles after a capture at pc=0x10 -> state stays DRAIN, imem_req=0, pc_next=0x14 held. On id_ready=1, transfer occurs and REQ follows the next cycle with imem_addr=0x14.
- redirect_valid with target 0x103 while in WAIT, rvalid 2 cycles later with rdata=0xDEADBEEF -> pc_next=0x100. The response is dropped, if_valid stays 0, and the next request uses imem_addr=0x100.
- Redirect in the same cycle as rvalid, and redirect in DRAIN with id_ready=1 -> no capture or transfer, if_valid=0, and state goes to REQ next cycle.
- pc=0xFFFFFFFC capture -> pc_next=0x00000000.
- rst pulled low asynchronously mid-WAIT -> all outputs return to reset values at once. An rvalid arriving during IDLE is ignored. With FETCH_PERF_EN, both counters read 0.
